pmem_responder: RTL and testbench

Physical-memory-side responder for the cache's pmem interface: accepts line-sized read and write requests from the cache controller, waits a fixed programmable latency, then completes them with a one-cycle `pmem_resp` pulse. Backs requests with an internal line array. Serves as the far end of the cache-to-memory link in simulation and on FPGA builds, in place of the off-chip memory.

---
 rtl/lc3b_types.sv | 16 +
 rtl/pmem_array.sv | 36 +++
 rtl/pmem_responder.sv | 144 ++++++++++++++
 tb/tb_pmem_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the cache/memory link, plus the memory responder's
// state encoding and line-offset width.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  localparam int PMEM_OFFSET_BITS = 4;

endpackage

// File: rtl/pmem_array.sv
// Line storage for pmem_responder: one write port and one registered read port.
// Only the read register is reset; the line contents are not.
module pmem_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LINES = 64,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  lc3b_block        wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] ridx,
  output lc3b_block        rdata
);

  lc3b_block mem [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Holds the last line read until the next read is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency pmem responder backed by an internal line array.
// Define PMEM_STATS_EN to add the read_count/write_count completion counters.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY     = 8,
  parameter int DEPTH_LINES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  lc3b_word    pmem_address,
  input  lc3b_block   pmem_wdata,
  output lc3b_block   pmem_rdata,
  output logic        pmem_resp,
`ifdef PMEM_STATS_EN
  output logic [31:0] read_count,
  output logic [31:0] write_count,
`endif
  output logic        busy
);

  localparam int IDX_W    = $clog2(DEPTH_LINES);
  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam bit SINGLE_CYCLE = (LATENCY == 1);

  pmem_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             op_write_reg;
  lc3b_block        wdata_reg;
  logic             resp_reg;
  logic             busy_reg;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             accept;
  logic             rd_fire;
  logic             arr_we;
  logic             unused_addr;

  assign req_idx     = pmem_address[PMEM_OFFSET_BITS +: IDX_W];
  assign unused_addr = ^pmem_address;
  assign accept      = (state_reg == IDLE) && (pmem_read || pmem_write);

  // The read is issued on the edge entering RESP; at LATENCY 1 that is the
  // accepting edge itself, so the index comes straight from the address.
  assign rd_fire = (SINGLE_CYCLE && accept && !pmem_write) ||
                   ((state_reg == BUSY) && (cnt_reg == '0) && !op_write_reg);
  assign rd_idx  = (state_reg == IDLE) ? req_idx : idx_reg;
  assign arr_we  = (state_reg == RESP) && op_write_reg;

  pmem_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .widx  (idx_reg),
    .wdata (wdata_reg),
    .re    (rd_fire),
    .ridx  (rd_idx),
    .rdata (pmem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      op_write_reg <= 1'b0;
      wdata_reg    <= '0;
      resp_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          resp_reg <= 1'b0;
          busy_reg <= 1'b0;
          if (accept) begin
            idx_reg      <= req_idx;
            op_write_reg <= pmem_write;
            wdata_reg    <= pmem_wdata;
            busy_reg     <= 1'b1;
            if (SINGLE_CYCLE) begin
              state_reg <= RESP;
              resp_reg  <= 1'b1;
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= CNT_W'(CNT_INIT);
            end
          end
        end
        BUSY: begin
          busy_reg <= 1'b1;
          if (cnt_reg == '0) begin
            state_reg <= RESP;
            resp_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        RESP: begin
          state_reg <= IDLE;
          resp_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          resp_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_resp = resp_reg;
  assign busy      = busy_reg;

`ifdef PMEM_STATS_EN
  logic [31:0] read_count_reg;
  logic [31:0] write_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_count_reg  <= '0;
      write_count_reg <= '0;
    end else if (state_reg == RESP) begin
      if (op_write_reg) begin
        write_count_reg <= write_count_reg + 32'd1;
      end else begin
        read_count_reg <= read_count_reg + 32'd1;
      end
    end
  end

  assign read_count  = read_count_reg;
  assign write_count = write_count_reg;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a LATENCY=8 instance and a LATENCY=1
// instance share stimulus; each check targets one of them.
module tb_pmem_responder;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pmem_read = 1'b0;
  logic        pmem_write = 1'b0;
  lc3b_word    pmem_address = '0;
  lc3b_block   pmem_wdata = '0;

  lc3b_block   rdata8, rdata1;
  logic        resp8, resp1, busy8, busy1;
`ifdef PMEM_STATS_EN
  logic [31:0] rcnt8, wcnt8, rcnt1, wcnt1;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pmem_responder #(.LATENCY(8), .DEPTH_LINES(64)) dut8 (
    .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(rdata8),
    .pmem_resp(resp8),
`ifdef PMEM_STATS_EN
    .read_count(rcnt8), .write_count(wcnt8),
`endif
    .busy(busy8)
  );

  pmem_responder #(.LATENCY(1), .DEPTH_LINES(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(rdata1),
    .pmem_resp(resp1),
`ifdef PMEM_STATS_EN
    .read_count(rcnt1), .write_count(wcnt1),
`endif
    .busy(busy1)
  );

  typedef struct {
    logic       rd;
    logic       wr;
    logic [15:0] addr;
    logic [127:0] wd;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  localparam logic [127:0] D0   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D1   = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
  localparam logic [127:0] D2   = 128'h5555AAAA3333CCCC0F0FF0F01111EEEE;
  localparam logic [127:0] D3   = 128'hBADC0FFEE0DDF00D0000111122223333;
  localparam logic [127:0] ONES = {128{1'b1}};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request held until the response, then dropped the cycle after it.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [127:0] wd, input logic [127:0] exp,
                     input int lat, input bit sel1, input string name);
    int got;
    got = -1;
    @(posedge clk); #1;
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if ((sel1 ? resp1 : resp8) === 1'b1) begin
        got = k;
        break;
      end
    end
    chk({name, "_latency"}, 128'(got), 128'(lat));
    if (got > 0) begin
      chk({name, "_rdata"}, sel1 ? rdata1 : rdata8, exp);
      chk({name, "_busy_resp"}, 128'(sel1 ? busy1 : busy8), 128'(1));
    end
    @(posedge clk); #1;
    pmem_read = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
    chk({name, "_single_pulse"}, 128'(sel1 ? resp1 : resp8), 128'(0));
    chk({name, "_busy_after"}, 128'(sel1 ? busy1 : busy8), 128'(0));
    @(negedge clk);
    chk({name, "_no_second"}, 128'(sel1 ? resp1 : resp8), 128'(0));
    $display("txn %-8s rd=%0b wr=%0b addr=%h resp_cycle=%0d rdata=%h",
             name, rd, wr, addr, got, sel1 ? rdata1 : rdata8);
  endtask

  initial begin
    logic [4:0] pat;
    int pulses;

    vecs[0] = '{1'b0, 1'b1, 16'h0040, D0,   128'h0};
    vecs[1] = '{1'b1, 1'b0, 16'h004F, '0,   D0};
    vecs[2] = '{1'b0, 1'b1, 16'h0020, D1,   D0};
    vecs[3] = '{1'b1, 1'b0, 16'h0020, '0,   D1};
    vecs[4] = '{1'b1, 1'b1, 16'h0010, ONES, D1};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, '0,   ONES};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, D2,   ONES};
    vecs[7] = '{1'b1, 1'b0, 16'h0400, '0,   D2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp8", 128'(resp8), 128'(0));
    chk("rst_busy8", 128'(busy8), 128'(0));
    chk("rst_rdata8", rdata8, 128'h0);
    chk("rst_resp1", 128'(resp1), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp, 8, 1'b0,
          $sformatf("v%0d", i));
    end
`ifdef PMEM_STATS_EN
    chk("read_count", 128'(rcnt8), 128'(4));
    chk("write_count", 128'(wcnt8), 128'(4));
`endif

    // LATENCY=1: single read, then a held read giving pulses in cycles 1,3,5.
    txn(1'b1, 1'b0, 16'h0010, '0, ONES, 1, 1'b1, "l1_rd");
    repeat (12) @(posedge clk);
    @(posedge clk); #1;
    pmem_read = 1'b1; pmem_address = 16'h0040;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      pat[k] = resp1;
    end
    chk("l1_b2b_pattern", 128'(pat), 128'(5'b10101));
    chk("l1_b2b_rdata", rdata1, D0);
    $display("txn l1_b2b   rd=1 wr=0 addr=0040 pulses=%b", pat);
    @(posedge clk); #1;
    pmem_read = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in cycle 4 of a LATENCY=8 write: nothing completes or commits.
    @(posedge clk); #1;
    pmem_write = 1'b1; pmem_address = 16'h0020; pmem_wdata = D3;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
    chk("abort_resp", 128'(resp8), 128'(0));
    chk("abort_busy", 128'(busy8), 128'(0));
    chk("abort_rdata", rdata8, 128'h0);
`ifdef PMEM_STATS_EN
    chk("abort_wcount", 128'(wcnt8), 128'(0));
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp8 === 1'b1) pulses++;
    end
    chk("abort_no_resp", 128'(pulses), 128'(0));
    $display("txn abort    wr=1 addr=0020 resp_pulses=%0d", pulses);
    txn(1'b1, 1'b0, 16'h0020, '0, D1, 8, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
